// File: rtl/queue_counter.sv
// rtl/queue_counter.sv - queue occupancy counter with edge-detected sensors and wait-time estimate
module queue_counter #(
   parameter int MAX_COUNT = 7,
   parameter int WT_UNIT   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up_in,
   input  logic       down_in,
   input  logic [1:0] tcount,
   output logic [2:0] pcount,
   output logic [4:0] wtime,
   output logic       full,
   output logic       empty,
   output logic       err
);

   localparam logic [2:0] max_c = 3'(MAX_COUNT);
   localparam logic [4:0] wt_u  = 5'(WT_UNIT);

   logic       up_prev;
   logic       down_prev;
   logic       up_evt;
   logic       dn_evt;
   logic [4:0] num;
   logic [4:0] quot;
   logic [4:0] wtime_next;

   assign up_evt = up_in & ~up_prev;
   assign dn_evt = down_in & ~down_prev;
   assign full   = (pcount == max_c);
   assign empty  = (pcount == 3'd0);

   // Largest numerator is 3 * (7 + 3 - 1) = 27, so 5 bits never overflow.
   always_comb begin
      num        = wt_u * ({2'b00, pcount} + {3'b000, tcount} - 5'd1);
      quot       = '0;
      wtime_next = '0;
      case (tcount)
         2'd1:    quot = num;
         2'd2:    quot = num >> 1;
         2'd3:    quot = num / 5'd3;
         default: quot = '0;
      endcase
      if (pcount != 3'd0 && tcount != 2'd0)
         wtime_next = quot;
   end

   always_ff @(posedge clk) begin
      up_prev   <= up_in;
      down_prev <= down_in;
      if (rst) begin
         pcount <= '0;
         wtime  <= '0;
         err    <= 1'b0;
      end else begin
         err   <= 1'b0;
         wtime <= wtime_next;
         // Simultaneous up and down events cancel out without flagging an error.
         if (up_evt && !dn_evt) begin
            if (!full)
               pcount <= pcount + 3'd1;
            else
               err <= 1'b1;
         end else if (dn_evt && !up_evt) begin
            if (!empty)
               pcount <= pcount - 3'd1;
            else
               err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_queue_counter.sv
// tb/tb_queue_counter.sv - directed self-checking bench for queue_counter
module tb_queue_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       up_in;
   logic       down_in;
   logic [1:0] tcount;
   logic [2:0] pcount;
   logic [4:0] wtime;
   logic       full;
   logic       empty;
   logic       err;

   int passed = 0;
   int total  = 0;
   int err_seen;

   queue_counter #(.MAX_COUNT(7), .WT_UNIT(3)) dut (
      .clk(clk), .rst(rst), .up_in(up_in), .down_in(down_in), .tcount(tcount),
      .pcount(pcount), .wtime(wtime), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic pulse_up();
      up_in = 1'b1; tick();
      up_in = 1'b0; tick();
   endtask

   task automatic pulse_down();
      down_in = 1'b1; tick();
      down_in = 1'b0; tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); tick();
      rst = 1'b0;
   endtask

   initial begin
      up_in = 1'b0; down_in = 1'b0; tcount = 2'd1;
      do_reset();
      chk("rst_pcount", 32'(pcount), 0);
      chk("rst_wtime",  32'(wtime), 0);
      chk("rst_empty",  32'(empty), 1);
      chk("rst_full",   32'(full), 0);
      chk("rst_err",    32'(err), 0);

      // three single pulses, tcount=1: wtime trails pcount by one clock
      up_in = 1'b1; tick();
      chk("p1_pcount", 32'(pcount), 1);
      chk("p1_empty",  32'(empty), 0);
      chk("p1_wtime_lag", 32'(wtime), 0);
      up_in = 1'b0; tick();
      chk("p1_wtime", 32'(wtime), 3);
      up_in = 1'b1; tick();
      chk("p2_pcount", 32'(pcount), 2);
      chk("p2_wtime_lag", 32'(wtime), 3);
      up_in = 1'b0; tick();
      chk("p2_wtime", 32'(wtime), 6);
      up_in = 1'b1; tick();
      chk("p3_pcount", 32'(pcount), 3);
      chk("p3_wtime_lag", 32'(wtime), 6);
      up_in = 1'b0; tick();
      chk("p3_wtime", 32'(wtime), 9);

      // held level from pcount=2 counts once
      pulse_down();
      chk("hold_start", 32'(pcount), 2);
      up_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_pcount", 32'(pcount), 3);
         chk("hold_err", 32'(err), 0);
      end
      up_in = 1'b0; tick();

      // saturate at 7 with exactly one err pulse
      do_reset();
      err_seen = 0;
      for (int i = 1; i <= 8; i++) begin
         up_in = 1'b1; tick();
         chk("sat_pcount", 32'(pcount), (i < 7) ? i : 7);
         chk("sat_err_edge", 32'(err), (i == 8) ? 1 : 0);
         if (err) err_seen++;
         up_in = 1'b0; tick();
         chk("sat_err_after", 32'(err), 0);
         if (err) err_seen++;
      end
      chk("sat_full", 32'(full), 1);
      chk("sat_err_count", 32'(err_seen), 1);

      // simultaneous up and down at pcount=4
      pulse_down(); pulse_down(); pulse_down();
      chk("sim_start", 32'(pcount), 4);
      up_in = 1'b1; down_in = 1'b1; tick();
      chk("sim_pcount", 32'(pcount), 4);
      chk("sim_err", 32'(err), 0);
      up_in = 1'b0; down_in = 1'b0; tick();
      chk("sim_pcount2", 32'(pcount), 4);

      // down while empty
      do_reset();
      down_in = 1'b1; tick();
      chk("und_pcount", 32'(pcount), 0);
      chk("und_err", 32'(err), 1);
      down_in = 1'b0; tick();
      chk("und_err_clear", 32'(err), 0);
      chk("und_pcount2", 32'(pcount), 0);

      // wtime vs tcount, then reset with up held
      tcount = 2'd3;
      for (int i = 0; i < 5; i++) pulse_up();
      chk("wt_pcount5", 32'(pcount), 5);
      chk("wt_t3", 32'(wtime), 7);
      tcount = 2'd2;
      chk("wt_t2_before", 32'(wtime), 7);
      tick();
      chk("wt_t2", 32'(wtime), 9);
      tcount = 2'd0; tick();
      chk("wt_t0", 32'(wtime), 0);
      up_in = 1'b1; rst = 1'b1; tick();
      chk("rp_pcount", 32'(pcount), 0);
      chk("rp_err", 32'(err), 0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("rp_after_pcount", 32'(pcount), 0);
      chk("rp_after_err", 32'(err), 0);
      chk("rp_after_empty", 32'(empty), 1);
      up_in = 1'b0; tick();
      chk("rp_release_pcount", 32'(pcount), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/queue_counter.md
QUEUE_COUNTER -- requirements
Module: queue_counter

Interface
REQ-001 The block SHALL have parameter MAX_COUNT, default 7, giving the maximum queue occupancy (legal range 1..7).
REQ-002 The block SHALL have parameter WT_UNIT, default 3, giving the service minutes per customer per teller (legal range 1..3).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port up_in, input, 1 bit, the debounced level of the customer-entry sensor, synchronous to clk.
REQ-006 The block SHALL have port down_in, input, 1 bit, the debounced level of the customer-exit sensor, synchronous to clk.
REQ-007 The block SHALL have port tcount, input, 2 bits, the number of active tellers (0..3), treated as quasi-static.
REQ-008 The block SHALL have port pcount, output, 3 bits, the registered count of people in the queue.
REQ-009 The block SHALL have port wtime, output, 5 bits, the registered estimated wait time in minutes.
REQ-010 The block SHALL have port full, output, 1 bit, which is high when pcount == MAX_COUNT.
REQ-011 The block SHALL have port empty, output, 1 bit, which is high when pcount == 0.
REQ-012 The block SHALL have port err, output, 1 bit, a one-cycle pulse flagging a rejected event.

Function
REQ-013 The block SHALL register up_in and down_in into up_prev and down_prev every cycle.
REQ-014 The block SHALL generate up_evt = up_in & ~up_prev and dn_evt = down_in & ~down_prev; only 0->1 transitions count, and a held level counts once.
REQ-015 On an edge with up_evt=1, dn_evt=0 and pcount < MAX_COUNT, the block SHALL increment pcount by 1 on that same edge.
REQ-016 On an edge with dn_evt=1, up_evt=0 and pcount > 0, the block SHALL decrement pcount by 1 on that same edge.
REQ-017 When up_evt and dn_evt are both 1 on the same edge, the block SHALL leave pcount unchanged and keep err low.
REQ-018 When up_evt=1 while full, the block SHALL hold pcount (no wrap to 0) and pulse err high for exactly the next cycle.
REQ-019 When dn_evt=1 while empty, the block SHALL hold pcount (no wrap to 7) and pulse err high for exactly the next cycle.
REQ-020 The block SHALL decode full and empty combinationally from the pcount register, so they are valid in the same cycle as pcount.
REQ-021 The block SHALL register wtime from the current pcount and tcount one cycle after pcount settles; wtime lags a pcount change by exactly 1 clock.
REQ-022 When pcount == 0 or tcount == 0, the block SHALL compute wtime = 0.
REQ-023 Otherwise the block SHALL compute wtime = floor(WT_UNIT * (pcount + tcount - 1) / tcount), in integer arithmetic wide enough that no intermediate overflows; the maximum result is 21, which fits in 5 bits.
REQ-024 The wtime computation SHALL be a lookup table or case decode with no multi-cycle divider.
REQ-025 A change on tcount alone SHALL update wtime one clock later.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set pcount=0 and wtime=0, drive err=0 on the following cycle, give full=0 (when MAX_COUNT>0), and give empty=1.
REQ-027 While rst=1, the block SHALL load up_prev and down_prev from the current up_in and down_in, so a level already high at reset release is not counted.
REQ-028 Reset SHALL take priority over any simultaneous up or down event.
REQ-029 Reset asserted mid-operation SHALL discard the count with no residual err pulse.

Verification
REQ-030 The bench SHALL apply rst for 2 cycles, then 3 separate up_in pulses with tcount=1, and check pcount 1,2,3, empty=0, and wtime 3,6,9, each appearing one clock after its pcount value.
REQ-031 The bench SHALL hold up_in high for 10 cycles starting from pcount=2 and check that pcount becomes 3 once and stays 3.
REQ-032 The bench SHALL apply 8 up pulses starting from empty and check that pcount saturates at 7, full=1, and err pulses exactly once (on the 8th).
REQ-033 The bench SHALL assert up_in and down_in rising together on the same edge at pcount=4 and check that pcount stays 4 and err=0.
REQ-034 The bench SHALL apply a down pulse at pcount=0 and check that pcount stays 0 (no wrap) and err pulses for 1 cycle.
REQ-035 The bench SHALL set pcount=5 with tcount=3, then change tcount to 2, and check wtime 7 then 9; it SHALL then set tcount=0 and check wtime 0; it SHALL then assert rst with up_in held high and check that pcount=0 and no count occurs after release.
